mc_delay_multi: RTL and testbench
=================================

# mc_delay_multi

Parametrised, multi-channel successor to the single-channel catch/delay timer. Each of `CH` independent channels latches a programmable delay when `io_catch` pulses. Exactly that many cycles later it emits a one-cycle `io_delay_end` pulse. Per-channel mode control selects one-shot-ignore, one-shot-restart or periodic re-arming, and channels can be cancelled with `io_stop`. The block sits between trigger sources and the motion/sequencing logic that consumes the delayed events.

## Interface
- `CH`, 4 — number of independent channels (1..32).
- `W`, 24 — delay/counter width in bits (2..32).
- `io_clk` in 1 — single clock; all state on rising edge.
- `io_rst_n` in 1 — asynchronous, active-low reset.
- `io_catch` in CH — per-channel trigger; level sampled every cycle, one pulse per cycle high.
- `io_delay` in CH*W — per-channel delay D, channel i at bits [i*W +: W], unsigned.
- `io_mode` in CH*2 — per-channel mode, channel i at [i*2 +: 2]; 00 ONESHOT_IGN, 01 ONESHOT_RST, 10 PERIODIC, 11 treated as 00.
- `io_stop` in CH — per-channel cancel.
- `io_delay_end` out CH — delay-expired pulse.
- `io_busy` out CH — channel armed/counting.
- `io_overrun` out CH — catch rejected, ONESHOT_IGN only.

## Operation
- Per-channel state:
  - `busy` (1b),
  - `cnt` (W bits),
  - `dly_q` (W bits, D latched at acceptance),
  - `mode_q` (2b, latched at acceptance).
- `expire = busy & (cnt == dly_q)`.
- Accept: a catch is accepted when `io_catch=1`, `io_stop=0`, D≠0, and any of the following holds:
  - the channel is idle, or
  - `expire=1`, or
  - `mode_q` is ONESHOT_RST or PERIODIC.
- On accept:
  - `busy<=1`, `cnt<=1`, `dly_q<=io_delay`, `mode_q<=io_mode`.
  - A restart discards the old count with no end pulse for the aborted interval.
- Counting, when `busy` and not `expire`: `cnt<=cnt+1`.
- On `expire` with no accept:
  - ONESHOT → `busy<=0`, `cnt<=0`.
  - PERIODIC → `cnt<=1`, giving period D until stopped.
- Stop:
  - `io_stop=1` forces `busy<=0`, `cnt<=0` next edge.
  - Stop beats catch in the same cycle.
  - A coincident `expire` pulse is still emitted.
- Zero delay:
  - D=0 is a combinational bypass: `io_delay_end = io_catch`.
  - No state change; the channel stays in its current state.
  - A D=0 catch on a busy channel does not disturb that channel's count.
- Outputs, per channel, combinational from registers plus inputs:
  - `io_delay_end = expire | (io_catch & (io_delay==0))`.
  - `io_busy = busy`.
  - `io_overrun = io_catch & busy & ~expire & (mode_q==ONESHOT_IGN) & (io_delay!=0) & ~io_stop`.
- Changes to `io_delay`/`io_mode` while busy have no effect until the next accept.
- The counter never wraps, because `cnt ≤ dly_q ≤ 2^W−1`. The maximum delay is 2^W−1 cycles.

## Timing
- Catch high in cycle 0 with D≥1 → `io_delay_end` high in cycle D exactly, for one cycle. `io_busy` is high in cycles 1..D.
- Back-to-back: a catch in cycle D (the expiry cycle) is accepted in every mode. The next end pulse is at cycle 2D.
- PERIODIC: end pulses at cycles D, 2D, 3D, … A catch in cycle k (busy) restarts the count, so the next pulse is at k+D.
- ONESHOT_IGN: a catch during cycles 1..D−1 → `io_overrun` high that cycle; the schedule is unchanged.
- Stop in cycle k → `io_busy` low from k+1; no pulse after k.
- Reset, asynchronous on `io_rst_n` low: `busy=0`, `cnt=0`, `dly_q=0`, `mode_q=00`. Then `io_busy=0`, `io_overrun=0`, and `io_delay_end` equals only the D=0 bypass term.
- Reset mid-count drops the pending pulse; no pulse follows release.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Structure
- Package `mc_delay_pkg`:
  - mode localparams `MODE_ONESHOT_IGN=2'b00`, `MODE_ONESHOT_RST=2'b01`, `MODE_PERIODIC=2'b10`;
  - defaults `MC_DELAY_W=24`, `MC_DELAY_CH=4`.
- Sub-module `mc_delay_chan` (parameter W) holds one channel's state and outputs.
- Top-level `mc_delay_multi` generates CH instances and slices the flat buses.

## Test plan
- W=8, ch0 ONESHOT_IGN, D=5: catch in cycle 0 → end in cycle 5 only, busy cycles 1–5; catch in cycle 2 → overrun cycle 2, end still cycle 5.
- ch1 ONESHOT_RST, D=5: catch in cycles 0 and 3 → single end in cycle 8.
- ch2 PERIODIC, D=3: catch in cycle 0 → ends at 3, 6, 9; stop in cycle 7 → busy low from 8, no end at 9. Stop+catch in the same cycle → idle.
- D=0 on ch3: catch in cycle 4 → end in cycle 4 combinationally, busy stays 0. D=255 (W=8 max) → end in cycle 255, no wrap.
- Catch in the expiry cycle (D=4, catches in cycles 0 and 4) → ends at 4 and 8. `io_delay` changed to 9 at cycle 2 → no effect on the current interval.
- `io_rst_n` low in cycle 3 of D=6 → all outputs at reset values, no end pulse. All four channels triggered simultaneously with distinct D → each ends at its own D.

Source files
------------

// File: rtl/mc_delay_pkg.sv
// +--------------------------------------------------------------------------+
// | mc_delay_pkg : shared modes and default sizes for the multi-channel timer |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package mc_delay_pkg;

  localparam logic [1:0] MODE_ONESHOT_IGN = 2'b00;
  localparam logic [1:0] MODE_ONESHOT_RST = 2'b01;
  localparam logic [1:0] MODE_PERIODIC    = 2'b10;

  localparam int MC_DELAY_W  = 24;
  localparam int MC_DELAY_CH = 4;

endpackage : mc_delay_pkg

`default_nettype wire

// File: rtl/mc_delay_multi_if.sv
// +--------------------------------------------------------------------------+
// | mc_delay_multi_if : trigger/control bus and event outputs of the timer    |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mc_delay_multi_if
  import mc_delay_pkg::*;
#(
  parameter int CH = MC_DELAY_CH,
  parameter int W  = MC_DELAY_W
) ();

  logic [CH-1:0]   io_catch;
  logic [CH*W-1:0] io_delay;
  logic [CH*2-1:0] io_mode;
  logic [CH-1:0]   io_stop;
  logic [CH-1:0]   io_delay_end;
  logic [CH-1:0]   io_busy;
  logic [CH-1:0]   io_overrun;

  modport master (
    output io_catch, io_delay, io_mode, io_stop,
    input  io_delay_end, io_busy, io_overrun
  );

  modport slave (
    input  io_catch, io_delay, io_mode, io_stop,
    output io_delay_end, io_busy, io_overrun
  );

endinterface : mc_delay_multi_if

`default_nettype wire

// File: rtl/mc_delay_chan.sv
// +--------------------------------------------------------------------------+
// | mc_delay_chan : one catch/delay channel with ignore/restart/periodic modes|
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module mc_delay_chan
  import mc_delay_pkg::*;
#(
  parameter int W = MC_DELAY_W
) (
  input  logic         io_clk,
  input  logic         io_rst_n,
  input  logic         io_catch,
  input  logic [W-1:0] io_delay,
  input  logic [1:0]   io_mode,
  input  logic         io_stop,
  output logic         io_delay_end,
  output logic         io_busy,
  output logic         io_overrun
);

  logic         r_busy;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_dly_q;
  logic [1:0]   r_mode_q;

  logic         w_expire;
  logic         w_dzero;
  logic         w_rearm;
  logic         w_accept;
  logic [1:0]   w_mode_n;

  // Mode 11 is folded into ONESHOT_IGN at latch time so all later decodes see one encoding.
  assign w_mode_n = (io_mode == 2'b11) ? MODE_ONESHOT_IGN : io_mode;

  assign w_expire = r_busy && (r_cnt == r_dly_q);
  assign w_dzero  = (io_delay == '0);
  assign w_rearm  = (r_mode_q == MODE_ONESHOT_RST) || (r_mode_q == MODE_PERIODIC);
  assign w_accept = io_catch && !io_stop && !w_dzero && (!r_busy || w_expire || w_rearm);

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_dly_q  <= '0;
      r_mode_q <= MODE_ONESHOT_IGN;
    end else if (io_stop) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_busy   <= 1'b1;
      r_cnt    <= {{(W-1){1'b0}}, 1'b1};
      r_dly_q  <= io_delay;
      r_mode_q <= w_mode_n;
    end else if (w_expire) begin
      if (r_mode_q == MODE_PERIODIC) begin
        r_cnt <= {{(W-1){1'b0}}, 1'b1};
      end else begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A zero delay bypasses the counter entirely and never touches channel state.
  assign io_delay_end = w_expire || (io_catch && w_dzero);
  assign io_busy      = r_busy;
  assign io_overrun   = io_catch && r_busy && !w_expire && (r_mode_q == MODE_ONESHOT_IGN)
                        && !w_dzero && !io_stop;

endmodule : mc_delay_chan

`default_nettype wire

// File: rtl/mc_delay_multi.sv
// +--------------------------------------------------------------------------+
// | mc_delay_multi : CH independent catch/delay timers on flat sliced buses   |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module mc_delay_multi
  import mc_delay_pkg::*;
#(
  parameter int CH = MC_DELAY_CH,
  parameter int W  = MC_DELAY_W
) (
  input  logic              io_clk,
  input  logic              io_rst_n,
  mc_delay_multi_if.slave   bus
);

  logic [CH-1:0] w_delay_end;
  logic [CH-1:0] w_busy;
  logic [CH-1:0] w_overrun;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    mc_delay_chan #(
      .W (W)
    ) u_chan (
      .io_clk       (io_clk),
      .io_rst_n     (io_rst_n),
      .io_catch     (bus.io_catch[i]),
      .io_delay     (bus.io_delay[i*W +: W]),
      .io_mode      (bus.io_mode[i*2 +: 2]),
      .io_stop      (bus.io_stop[i]),
      .io_delay_end (w_delay_end[i]),
      .io_busy      (w_busy[i]),
      .io_overrun   (w_overrun[i])
    );
  end : g_chan

  assign bus.io_delay_end = w_delay_end;
  assign bus.io_busy      = w_busy;
  assign bus.io_overrun   = w_overrun;

endmodule : mc_delay_multi

`default_nettype wire

// File: tb/tb_mc_delay_multi.sv
// +--------------------------------------------------------------------------+
// | tb_mc_delay_multi : directed checks of the multi-channel delay timer      |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mc_delay_multi;

  localparam int CH = 4;
  localparam int W  = 8;

  logic io_clk;
  logic io_rst_n;
  int   n_chk;
  int   n_bad;

  mc_delay_multi_if #(.CH(CH), .W(W)) bus ();

  mc_delay_multi #(
    .CH (CH),
    .W  (W)
  ) dut (
    .io_clk   (io_clk),
    .io_rst_n (io_rst_n),
    .bus      (bus)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d, input logic [1:0] m);
    bus.io_delay[ch*W +: W] = d;
    bus.io_mode[ch*2 +: 2]  = m;
  endtask

  task automatic idle_all();
    bus.io_catch = '0;
    bus.io_stop  = '1;
    tick();
    bus.io_stop  = '0;
  endtask

  // Bit c of each trace holds the channel output seen in cycle c of the run.
  task automatic run_ch(input int ch, input int n, input logic [31:0] cm, input logic [31:0] sm,
                        input int chg_c, input logic [7:0] chg_v,
                        output logic [31:0] oe, output logic [31:0] ob, output logic [31:0] oo);
    oe = '0; ob = '0; oo = '0;
    for (int c = 0; c < n; c++) begin
      if (c == chg_c) bus.io_delay[ch*W +: W] = chg_v;
      bus.io_catch[ch] = cm[c];
      bus.io_stop[ch]  = sm[c];
      #2;
      oe[c] = bus.io_delay_end[ch];
      ob[c] = bus.io_busy[ch];
      oo[c] = bus.io_overrun[ch];
      tick();
    end
    bus.io_catch[ch] = 1'b0;
    bus.io_stop[ch]  = 1'b0;
  endtask

  logic [31:0] te, tb, to;
  logic [31:0] e_all [CH];
  int          first_c, n_end, n_busy;

  initial begin
    n_chk = 0;
    n_bad = 0;
    io_rst_n   = 1'b0;
    bus.io_catch = '0;
    bus.io_stop  = '0;
    bus.io_delay = {8'd0, 8'd5, 8'd5, 8'd5};
    bus.io_mode  = '0;

    // Reset state, with the D=0 bypass still live on ch3.
    #2;
    bus.io_catch = 4'b1000;
    #2;
    chk("rst_end", {28'd0, bus.io_delay_end}, 32'h8);
    chk("rst_busy", {28'd0, bus.io_busy}, 32'h0);
    chk("rst_ovr", {28'd0, bus.io_overrun}, 32'h0);
    bus.io_catch = '0;
    tick(); tick();
    io_rst_n = 1'b1;
    tick();

    // ONESHOT_IGN D=5, catches in 0 and 2.
    set_ch(0, 8'd5, 2'b00);
    run_ch(0, 8, 32'h5, 32'h0, -1, 8'd0, te, tb, to);
    chk("ign_end", te, 32'h20);
    chk("ign_busy", tb, 32'h3E);
    chk("ign_ovr", to, 32'h4);
    idle_all();

    // Mode 11 behaves as ONESHOT_IGN.
    set_ch(0, 8'd5, 2'b11);
    run_ch(0, 8, 32'h5, 32'h0, -1, 8'd0, te, tb, to);
    chk("m11_end", te, 32'h20);
    chk("m11_ovr", to, 32'h4);
    idle_all();

    // ONESHOT_RST D=5, catches in 0 and 3.
    set_ch(1, 8'd5, 2'b01);
    run_ch(1, 11, 32'h9, 32'h0, -1, 8'd0, te, tb, to);
    chk("rst1_end", te, 32'h100);
    chk("rst1_busy", tb, 32'h1FE);
    chk("rst1_ovr", to, 32'h0);
    idle_all();

    // PERIODIC D=3, stop in 7.
    set_ch(2, 8'd3, 2'b10);
    run_ch(2, 11, 32'h1, 32'h80, -1, 8'd0, te, tb, to);
    chk("per_end", te, 32'h48);
    chk("per_busy", tb, 32'hFE);
    idle_all();

    // PERIODIC restart at cycle 4 -> pulses 3, 7, 10.
    run_ch(2, 12, 32'h11, 32'h0, -1, 8'd0, te, tb, to);
    chk("per_rst_end", te, 32'h488);
    chk("per_rst_busy", tb, 32'hFFE);
    idle_all();

    // Stop and catch together leaves the channel idle.
    run_ch(2, 4, 32'h1, 32'h1, -1, 8'd0, te, tb, to);
    chk("stopcat_busy", tb, 32'h0);
    chk("stopcat_end", te, 32'h0);
    idle_all();

    // D=0 bypass on idle ch3.
    set_ch(3, 8'd0, 2'b00);
    run_ch(3, 7, 32'h10, 32'h0, -1, 8'd0, te, tb, to);
    chk("d0_end", te, 32'h10);
    chk("d0_busy", tb, 32'h0);
    idle_all();

    // D=0 catch on a busy channel: bypass pulse, original schedule kept.
    set_ch(0, 8'd5, 2'b00);
    run_ch(0, 8, 32'h5, 32'h0, 2, 8'd0, te, tb, to);
    chk("d0busy_end", te, 32'h24);
    chk("d0busy_busy", tb, 32'h3E);
    chk("d0busy_ovr", to, 32'h0);
    idle_all();

    // Catch in the expiry cycle, D=4.
    set_ch(1, 8'd4, 2'b00);
    run_ch(1, 11, 32'h11, 32'h0, -1, 8'd0, te, tb, to);
    chk("b2b_end", te, 32'h110);
    chk("b2b_busy", tb, 32'h1FE);
    chk("b2b_ovr", to, 32'h0);
    idle_all();

    // Delay input changed mid-interval has no effect.
    set_ch(1, 8'd4, 2'b00);
    run_ch(1, 8, 32'h1, 32'h0, 2, 8'd9, te, tb, to);
    chk("dchg_end", te, 32'h10);
    chk("dchg_busy", tb, 32'h1E);
    idle_all();

    // Maximum delay D=255.
    set_ch(3, 8'd255, 2'b00);
    first_c = -1; n_end = 0; n_busy = 0;
    for (int c = 0; c < 260; c++) begin
      bus.io_catch[3] = (c == 0);
      #2;
      if (bus.io_delay_end[3]) begin
        if (first_c < 0) first_c = c;
        n_end++;
      end
      if (bus.io_busy[3]) n_busy++;
      tick();
    end
    chk("d255_first", first_c, 32'd255);
    chk("d255_count", n_end, 32'd1);
    chk("d255_busy", n_busy, 32'd255);
    idle_all();

    // Asynchronous reset in cycle 3 of a D=6 interval.
    set_ch(0, 8'd6, 2'b00);
    bus.io_catch[0] = 1'b1;
    tick();
    bus.io_catch[0] = 1'b0;
    tick(); tick();
    io_rst_n = 1'b0;
    #2;
    chk("arst_busy", {28'd0, bus.io_busy}, 32'h0);
    chk("arst_end", {28'd0, bus.io_delay_end}, 32'h0);
    tick();
    io_rst_n = 1'b1;
    n_end = 0; n_busy = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (bus.io_delay_end[0]) n_end++;
      if (bus.io_busy[0]) n_busy++;
      tick();
    end
    chk("arst_noend", n_end, 32'd0);
    chk("arst_nobusy", n_busy, 32'd0);

    // All channels at once with distinct delays.
    bus.io_delay = {8'd2, 8'd7, 8'd5, 8'd3};
    bus.io_mode  = '0;
    for (int i = 0; i < CH; i++) e_all[i] = '0;
    for (int c = 0; c < 10; c++) begin
      bus.io_catch = (c == 0) ? 4'hF : 4'h0;
      #2;
      for (int i = 0; i < CH; i++) e_all[i][c] = bus.io_delay_end[i];
      tick();
    end
    chk("all_ch0", e_all[0], 32'h8);
    chk("all_ch1", e_all[1], 32'h20);
    chk("all_ch2", e_all[2], 32'h80);
    chk("all_ch3", e_all[3], 32'h4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_mc_delay_multi

`default_nettype wire
